// File: rtl/rgb_sobel_pipe_pkg.sv
// Shared constants for the RGB -> luma -> Sobel edge pipeline.
package rgb_sobel_pipe_pkg;
  localparam int          COORD_W_DEF = 16;
  localparam logic [15:0] COEF_R      = 16'd77;
  localparam logic [15:0] COEF_G      = 16'd150;
  localparam logic [15:0] COEF_B      = 16'd29;
  localparam int          GRAY_SHIFT  = 8;
  localparam logic [7:0]  SAT_MAX     = 8'd255;

  typedef logic signed [10:0] grad_t;

  // Zero-extend a luma sample into the signed gradient domain.
  function automatic grad_t ext11(input logic [7:0] v);
    return grad_t'({3'b000, v});
  endfunction
endpackage

// File: rtl/rgb_sobel_pipe_rgb2gray.sv
// Luma conversion with its first output register.
module rgb2gray
  import rgb_sobel_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_i,
  input  logic [7:0] r_i,
  input  logic [7:0] g_i,
  input  logic [7:0] b_i,
  output logic       valid_o,
  output logic [7:0] gray_o
);
  logic [15:0] sum_d;
  logic [15:0] shr_d;

  // Coefficients total 256, so the 16-bit sum never overflows.
  always_comb begin
    sum_d = COEF_R * {8'h00, r_i} + COEF_G * {8'h00, g_i} + COEF_B * {8'h00, b_i};
    shr_d = sum_d >> GRAY_SHIFT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      gray_o  <= '0;
    end else begin
      valid_o <= valid_i;
      gray_o  <= shr_d[7:0];
    end
  end
endmodule

// File: rtl/rgb_sobel_pipe.sv
// Streaming RGB -> luma -> 3x3 Sobel magnitude, tagged with the window centre.
module rgb_sobel_pipe
  import rgb_sobel_pipe_pkg::*;
#(
  parameter int IMAGE_WIDTH = 320,
  parameter int COORD_W     = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [7:0]         in_r,
  input  logic [7:0]         in_g,
  input  logic [7:0]         in_b,
  output logic               out_valid,
  output logic [7:0]         out_pixel,
  output logic [COORD_W-1:0] out_row,
  output logic [COORD_W-1:0] out_col
);
  localparam int                 AW       = $clog2(IMAGE_WIDTH);
  localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMAGE_WIDTH - 1);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

  logic       g1_vld;
  logic [7:0] g1_gray;
  logic       g2_vld_q;
  logic [7:0] g2_gray_q;

  rgb2gray u_gray (
    .clk     (clk),
    .rst     (rst),
    .valid_i (in_valid),
    .r_i     (in_r),
    .g_i     (in_g),
    .b_i     (in_b),
    .valid_o (g1_vld),
    .gray_o  (g1_gray)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g2_vld_q  <= 1'b0;
      g2_gray_q <= '0;
    end else begin
      g2_vld_q  <= g1_vld;
      g2_gray_q <= g1_gray;
    end
  end

  logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
  logic [AW-1:0]      col_idx;
  logic [7:0]         lb_old_q  [IMAGE_WIDTH];
  logic [7:0]         lb_prev_q [IMAGE_WIDTH];
  logic [7:0]         rd_old, rd_prev;
  logic [2:0][2:0][7:0] win_q, win_d;

  logic               emit_d, zero_d;
  logic [COORD_W-1:0] crow_d, ccol_d;
  grad_t              gx_d, gy_d;

  logic               grad_vld_q, zero_q;
  logic [COORD_W-1:0] crow_q, ccol_q;
  grad_t              gx_q, gy_q;

  assign col_idx = col_q[AW-1:0];

  // win_d is the window including the pixel being accepted this cycle;
  // the gradient is taken on it so the window and gradient register together.
  always_comb begin
    rd_old  = lb_old_q[col_idx];
    rd_prev = lb_prev_q[col_idx];
    win_d   = win_q;
    col_d   = col_q;
    row_d   = row_q;
    if (g2_vld_q) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = rd_old;
      win_d[1][2] = rd_prev;
      win_d[2][2] = g2_gray_q;
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + ONE;
      end else begin
        col_d = col_q + ONE;
      end
    end
    emit_d = g2_vld_q && (row_q != '0) && (col_q != '0);
    zero_d = (row_q == ONE) || (col_q == ONE);
    crow_d = row_q - ONE;
    ccol_d = col_q - ONE;
    gx_d = ext11(win_d[0][2]) + (ext11(win_d[1][2]) <<< 1) + ext11(win_d[2][2])
         - ext11(win_d[0][0]) - (ext11(win_d[1][0]) <<< 1) - ext11(win_d[2][0]);
    gy_d = ext11(win_d[2][0]) + (ext11(win_d[2][1]) <<< 1) + ext11(win_d[2][2])
         - ext11(win_d[0][0]) - (ext11(win_d[0][1]) <<< 1) - ext11(win_d[0][2]);
  end

  // Line buffers are plain RAM: no reset, read-before-write at col.
  always_ff @(posedge clk) begin
    if (g2_vld_q) begin
      lb_old_q[col_idx]  <= rd_prev;
      lb_prev_q[col_idx] <= g2_gray_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      grad_vld_q <= 1'b0;
      zero_q     <= 1'b0;
      crow_q     <= '0;
      ccol_q     <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      win_q      <= win_d;
      grad_vld_q <= emit_d;
      if (emit_d) begin
        zero_q <= zero_d;
        crow_q <= crow_d;
        ccol_q <= ccol_d;
        gx_q   <= gx_d;
        gy_q   <= gy_d;
      end
    end
  end

  logic [10:0] ax, ay;
  logic [11:0] mag;
  logic [7:0]  pix_d;

  always_comb begin
    ax    = gx_q[10] ? $unsigned(-gx_q) : $unsigned(gx_q);
    ay    = gy_q[10] ? $unsigned(-gy_q) : $unsigned(gy_q);
    mag   = {1'b0, ax} + {1'b0, ay};
    pix_d = (mag > 12'd255) ? SAT_MAX : mag[7:0];
    if (zero_q) pix_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else begin
      out_valid <= grad_vld_q;
      if (grad_vld_q) begin
        out_pixel <= pix_d;
        out_row   <= crow_q;
        out_col   <= ccol_q;
      end
    end
  end
endmodule

// File: tb/tb_rgb_sobel_pipe.sv
// Self-checking bench: frame-level Sobel reference model with cycle-stamped scoreboard.
module tb_rgb_sobel_pipe;
  localparam int W  = 320;
  localparam int H  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_r = '0, in_g = '0, in_b = '0;
  logic          out_valid;
  logic [7:0]    out_pixel;
  logic [CW-1:0] out_row, out_col;

  int tests = 0, fails = 0, cyc = 0, rst_viol = 0;
  int max_row, max_col, st11, last_n;

  typedef struct {int cyc; int row; int col; int pix;} ev_t;
  ev_t obs_q[$];
  ev_t exp_q[$];
  int  gimg[H][W];
  int  obs_pix[H][W];

  rgb_sobel_pipe #(.IMAGE_WIDTH(W), .COORD_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_r      (in_r),
    .in_g      (in_g),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_row   (out_row),
    .out_col   (out_col)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) obs_q.push_back(ev_t'{cyc, int'(out_row), int'(out_col), int'(out_pixel)});
    if (rst && out_valid) rst_viol <= rst_viol + 1;
  end

  task automatic check(input string tag, input int got, input int expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int gray_ref(input int r, input int g, input int b);
    return (77 * r + 150 * g + 29 * b) / 256;
  endfunction

  // Sobel magnitude for a window centred at (cr,cc) of the stored frame.
  function automatic int sobel_ref(input int cr, input int cc);
    int gx, gy, m;
    if (cr == 0 || cc == 0) return 0;
    gx = (gimg[cr-1][cc+1] + 2 * gimg[cr][cc+1] + gimg[cr+1][cc+1])
       - (gimg[cr-1][cc-1] + 2 * gimg[cr][cc-1] + gimg[cr+1][cc-1]);
    gy = (gimg[cr+1][cc-1] + 2 * gimg[cr+1][cc] + gimg[cr+1][cc+1])
       - (gimg[cr-1][cc-1] + 2 * gimg[cr-1][cc] + gimg[cr-1][cc+1]);
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (m > 255) ? 255 : m;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int r, input int g, input int b, output int stamp);
    logic [31:0] rv, gv, bv;
    rv = r; gv = g; bv = b;
    in_valid = 1'b1;
    in_r = rv[7:0]; in_g = gv[7:0]; in_b = bv[7:0];
    stamp = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    idle(2);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  // mode 0: flat grey, 1: vertical edge at col 160, 2: random colour
  task automatic run_frame(input int mode, input bit gaps, input int stop_at);
    int r8, g8, b8, stamp;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r * W + c == stop_at) return;
        case (mode)
          0:       begin r8 = 100; g8 = 100; b8 = 100; end
          1:       begin r8 = (c < 160) ? 0 : 255; g8 = r8; b8 = r8; end
          default: begin r8 = $urandom_range(0, 255); g8 = $urandom_range(0, 255);
                         b8 = $urandom_range(0, 255); end
        endcase
        gimg[r][c] = gray_ref(r8, g8, b8);
        drive(r8, g8, b8, stamp);
        if (r == 1 && c == 1) st11 = stamp;
        if (r >= 1 && c >= 1)
          exp_q.push_back(ev_t'{stamp + 4, r - 1, c - 1, sobel_ref(r - 1, c - 1)});
        if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
    end
  endtask

  task automatic compare_all(input string tag);
    int n;
    last_n = obs_q.size();
    check({tag, " count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    max_row = -1; max_col = -1;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) obs_pix[r][c] = -1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d] cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s[%0d] row", tag, i), obs_q[i].row, exp_q[i].row);
      check($sformatf("%s[%0d] col", tag, i), obs_q[i].col, exp_q[i].col);
      check($sformatf("%s[%0d] pix", tag, i), obs_q[i].pix, exp_q[i].pix);
      if (obs_q[i].row >= 0 && obs_q[i].row < H && obs_q[i].col >= 0 && obs_q[i].col < W)
        obs_pix[obs_q[i].row][obs_q[i].col] = obs_q[i].pix;
      if (obs_q[i].row > max_row) max_row = obs_q[i].row;
      if (obs_q[i].col > max_col) max_col = obs_q[i].col;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  int gtab[5][3] = '{'{255, 0, 0}, '{0, 255, 0}, '{0, 0, 255}, '{255, 255, 255}, '{200, 200, 200}};

  initial begin
    int stamp, n;
    idle(2);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_pixel", int'(out_pixel), 0);
    check("reset out_row",   int'(out_row),   0);
    check("reset out_col",   int'(out_col),   0);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 5; i++) begin
      drive(gtab[i][0], gtab[i][1], gtab[i][2], stamp);
      check($sformatf("gray %0d", i), int'(dut.u_gray.gray_o),
            gray_ref(gtab[i][0], gtab[i][1], gtab[i][2]));
    end

    do_reset();
    run_frame(0, 1'b0, -1);
    idle(8);
    compare_all("flat");
    check("flat outputs", last_n, 3 * (W - 1));
    check("flat max_row", max_row, 2);
    check("flat max_col", max_col, W - 2);

    do_reset();
    run_frame(1, 1'b0, -1);
    idle(8);
    compare_all("edge");
    check("edge r1c159", obs_pix[1][159], 255);
    check("edge r1c160", obs_pix[1][160], 255);
    check("edge r1c158", obs_pix[1][158], 0);
    check("edge r1c161", obs_pix[1][161], 0);
    check("edge r0c159", obs_pix[0][159], 0);
    check("edge r0c160", obs_pix[0][160], 0);

    do_reset();
    run_frame(2, 1'b1, -1);
    idle(8);
    compare_all("rand");

    do_reset();
    run_frame(2, 1'b0, 2 * W + 100);
    rst = 1'b1;
    in_valid = 1'b0;
    idle(3);
    rst = 1'b0;
    check("midreset no out_valid", rst_viol, 0);
    n = obs_q.size();
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check($sformatf("pre-reset[%0d] pix", i), obs_q[i].pix, exp_q[i].pix);
    obs_q.delete();
    exp_q.delete();
    idle(1);
    check("midreset quiet", obs_q.size(), 0);
    run_frame(2, 1'b1, -1);
    idle(8);
    check("restart has output", int'(obs_q.size() > 0), 1);
    if (obs_q.size() > 0) begin
      check("restart first row", obs_q[0].row, 0);
      check("restart first col", obs_q[0].col, 0);
      check("restart first pix", obs_q[0].pix, 0);
      check("restart first cyc", obs_q[0].cyc, st11 + 4);
    end
    compare_all("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rgb_sobel_pipe.md
# rgb_sobel_pipe

Streaming edge-detection front end. It converts 24-bit RGB pixels to 8-bit luma, then applies a 3x3 Sobel operator over a raster-scanned image of fixed width. It sits between the pixel source and the frame writer. Each output is tagged with the row/column of its window centre so the consumer can place it in the frame.

## Interface
Parameters:
- IMAGE_WIDTH, 320: pixels per line; line-buffer depth.
- COORD_W, 16: width of the row/column counters and coordinate outputs.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  RGB pixel present this cycle; no backpressure.
- in_r  in  8  red.
- in_g  in  8  green.
- in_b  in  8  blue.
- out_valid  out  1  one-cycle strobe; out_pixel/out_row/out_col valid.
- out_pixel  out  8  Sobel magnitude.
- out_row  out  COORD_W  centre row of the window producing out_pixel.
- out_col  out  COORD_W  centre column of the window producing out_pixel.

## Operation
- Gray stage: gray = (77*R + 150*G + 29*B) >> 8, computed in 16-bit unsigned.
  - Registered once, then re-registered once: 2 register stages.
  - gray_valid follows in_valid through the same stages.
- Position counters (col, row) advance on each gray_valid.
  - col wraps IMAGE_WIDTH-1 -> 0 and increments row.
  - row is free-running; it wraps at 2^COORD_W.
  - Reset restarts the frame at (0,0).
- Line buffers: two IMAGE_WIDTH x 8 RAMs, indexed by col, holding the two previous lines. Read-before-write on each accepted gray pixel.
- Window: 3x3 shift registers p[r][c], r=0 oldest line, c=2 newest column; shifted left on each accepted pixel.
- Window centre for pixel (r,c) = (r-1, c-1).
  - Output emitted only when r>=1 and c>=1.
  - The last image row and last column are never emitted. The consumer pre-fills those positions with 0.
- Gx = (p02+2p12+p22) - (p00+2p10+p20).
- Gy = (p20+2p21+p22) - (p00+2p01+p02).
- Both computed as 11-bit signed.
- out_pixel = min(|Gx|+|Gy|, 255).
- Border rule: a centre on row 0 or column 0 outputs 0, with out_valid still asserted.
- A column wrap does not mix lines:
  - After col wraps to 0, no output is produced until c>=1.
  - The window at c=1 is only partially filled, but its centre is column 0, so it outputs 0 by the border rule.

## Timing
- Latency: in_valid at cycle N -> out_valid at cycle N+4.
  - N+1: gray register.
  - N+2: gray re-register.
  - N+3: window/line-buffer update + gradient register.
  - N+4: magnitude/saturate register.
- Throughput: one pixel per clock, sustained. Arbitrary gaps on in_valid are allowed. Outputs stay in input order.
- out_row/out_col are aligned with out_pixel on the same cycle.
- Reset values: out_valid=0, out_pixel=0, out_row=0, out_col=0.
- All pipeline valids and counters clear on reset. Line-buffer contents are don't-care.
- Reset mid-frame: in-flight pixels are discarded with no output. The first pixel after release is (0,0).

## Structure
- Shared package: gray coefficient constants (77/150/29, shift 8), the 255 saturation constant, and the COORD_W default.
- Sub-module rgb2gray: the gray stage including its first register.
- Everything else (second register, counters, line buffers, window, Sobel) lives in the top level: line buffers as inferred RAM arrays; window, gradient and magnitude registers inline.

## Test plan
- Gray coefficients, checked at the gray stage:
  - RGB (255,0,0) -> 76.
  - (0,255,0) -> 149.
  - (0,0,255) -> 28.
  - (255,255,255) -> 255.
  - (200,200,200) -> 200.
- Flat image, 320x4, all pixels (100,100,100) -> every emitted out_pixel = 0.
  - Exactly 3x319 = 957 outputs.
  - Coordinates cover rows 0..2, cols 0..318.
- Vertical edge, 320x4, cols <160 black, cols >=160 white:
  - Row 1, cols 159 and 160 -> 255 (saturated from 1020).
  - Row 1, cols 158 and 161 -> 0.
  - Row 0 -> 0.
- Latency/throughput:
  - Single isolated pixel -> out_valid exactly 4 cycles later.
  - Back-to-back 320-pixel lines -> out_valid every cycle except at c=0.
- Reset mid-frame: assert rst at pixel (2,100) for 3 cycles, then restart the frame.
  - No out_valid during reset.
  - First output after restart is (0,0) with value 0, 4 cycles after pixel (1,1) enters.
